// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data formatting, writeback source select,
// a saturating retired-instruction counter and a sticky halt flag.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_rdata,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_load_type,
    input  logic             in_reg_we,
    input  logic [4:0]       in_wr_num,
    input  logic             in_halt,
    output logic [4:0]       wb_num,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [31:0]      wb_pc,
    output logic             wb_valid,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count
);

    // No valid/ready handshake: stall freezes the stage, flush inserts a bubble
    // and wins over stall, otherwise the stage captures on every posedge.

    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;
    localparam logic [2:0] LT_LB    = 3'd1;
    localparam logic [2:0] LT_LBU   = 3'd2;
    localparam logic [2:0] LT_LH    = 3'd3;
    localparam logic [2:0] LT_LHU   = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        ev;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        align_bad;
    logic        misaligned;
    logic [31:0] link_data;
    logic [31:0] wr_data;
    logic        wr_en;

    assign ev        = in_valid & ~halted;
    assign off       = in_alu_result[1:0];
    assign link_data = in_pc + 32'd4;

    // Little-endian lane select: offset 0 is bits 7:0.
    always_comb begin
        ld_byte = in_mem_rdata[7:0];
        case (off)
            2'd0: ld_byte = in_mem_rdata[7:0];
            2'd1: ld_byte = in_mem_rdata[15:8];
            2'd2: ld_byte = in_mem_rdata[23:16];
            2'd3: ld_byte = in_mem_rdata[31:24];
            default: ld_byte = in_mem_rdata[7:0];
        endcase
        ld_half = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    end

    // Unknown load types fall through to the word path.
    always_comb begin
        ld_data   = in_mem_rdata;
        align_bad = (off != 2'd0);
        case (in_load_type)
            LT_LB: begin
                ld_data   = {{24{ld_byte[7]}}, ld_byte};
                align_bad = 1'b0;
            end
            LT_LBU: begin
                ld_data   = {24'h0, ld_byte};
                align_bad = 1'b0;
            end
            LT_LH: begin
                ld_data   = {{16{ld_half[15]}}, ld_half};
                align_bad = off[0];
            end
            LT_LHU: begin
                ld_data   = {16'h0, ld_half};
                align_bad = off[0];
            end
            default: begin
                ld_data   = in_mem_rdata;
                align_bad = (off != 2'd0);
            end
        endcase
    end

    assign misaligned = ev & in_reg_we & (in_wb_sel == SEL_LOAD) & align_bad;

    always_comb begin
        case (in_wb_sel)
            SEL_LOAD: wr_data = ld_data;
            SEL_LINK: wr_data = link_data;
            default:  wr_data = in_alu_result;
        endcase
    end

    assign wr_en = ev & in_reg_we & (in_wr_num != 5'd0) & ~misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_num        <= 5'd0;
            wb_data       <= 32'd0;
            wb_we         <= 1'b0;
            wb_pc         <= RESET_PC;
            wb_valid      <= 1'b0;
            misalign_err  <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            misalign_err <= 1'b0;
        end else if (stall) begin
            // The error is a pulse, so it must not persist across a stall.
            misalign_err <= 1'b0;
        end else begin
            wb_num       <= in_wr_num;
            wb_data      <= wr_data;
            wb_pc        <= in_pc;
            wb_valid     <= ev;
            wb_we        <= wr_en;
            misalign_err <= misaligned;
            if (ev && (retired_count != CNT_MAX)) begin
                retired_count <= retired_count + 1'b1;
            end
            if (ev && in_halt) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a behavioural model queues the expected
// writeback word for each capture, and each scenario task compares inline.
module tb_mem_wb_stage;

    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_pc = '0;
    logic [31:0]      in_alu_result = '0;
    logic [31:0]      in_mem_rdata = '0;
    logic [1:0]       in_wb_sel = '0;
    logic [2:0]       in_load_type = '0;
    logic             in_reg_we = 1'b0;
    logic [4:0]       in_wr_num = '0;
    logic             in_halt = 1'b0;
    logic [4:0]       wb_num;
    logic [31:0]      wb_data;
    logic             wb_we;
    logic [31:0]      wb_pc;
    logic             wb_valid;
    logic             misalign_err;
    logic             halted;
    logic [CNT_W-1:0] retired_count;

    mem_wb_stage #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
        .in_reg_we(in_reg_we), .in_wr_num(in_wr_num), .in_halt(in_halt),
        .wb_num(wb_num), .wb_data(wb_data), .wb_we(wb_we), .wb_pc(wb_pc),
        .wb_valid(wb_valid), .misalign_err(misalign_err), .halted(halted),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int               vectors = 0;
    int               miscompares = 0;
    logic [39:0]      exp_q[$];
    logic             model_halted = 1'b0;
    logic [CNT_W-1:0] model_cnt = '0;
    logic [39:0]      obs;
    logic [39:0]      exp_v;

    // Expected {valid, we, misalign, num, data} for the current inputs.
    function automatic logic [39:0] model_out();
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ld;
        logic [31:0] d;
        logic        ev;
        logic        mis;
        logic        we;
        b = 8'(in_mem_rdata >> (8 * in_alu_result[1:0]));
        h = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        case (in_load_type)
            3'd1:    ld = {{24{b[7]}}, b};
            3'd2:    ld = {24'h0, b};
            3'd3:    ld = {{16{h[15]}}, h};
            3'd4:    ld = {16'h0, h};
            default: ld = in_mem_rdata;
        endcase
        ev = in_valid && !model_halted;
        if (in_load_type == 3'd1 || in_load_type == 3'd2) mis = 1'b0;
        else if (in_load_type == 3'd3 || in_load_type == 3'd4) mis = in_alu_result[0];
        else mis = (in_alu_result[1:0] != 2'b00);
        mis = mis && ev && in_reg_we && (in_wb_sel == 2'd1);
        if (in_wb_sel == 2'd1) d = ld;
        else if (in_wb_sel == 2'd2) d = in_pc + 32'd4;
        else d = in_alu_result;
        we = ev && in_reg_we && (in_wr_num != 5'd0) && !mis;
        return {ev, we, mis, in_wr_num, d};
    endfunction

    // Drives one capture cycle, queues its expectation, returns #1 after the edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [1:0] sel, input logic [2:0] lt,
                         input logic we, input logic [4:0] num, input logic h);
        in_valid = v; in_pc = pc; in_alu_result = alu; in_mem_rdata = rd;
        in_wb_sel = sel; in_load_type = lt; in_reg_we = we; in_wr_num = num; in_halt = h;
        stall = 1'b0; flush = 1'b0;
        exp_q.push_back(model_out());
        if (v && !model_halted) begin
            if (model_cnt != '1) model_cnt = model_cnt + 1'b1;
            if (h) model_halted = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        model_halted = 1'b0;
        model_cnt = '0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({wb_valid, wb_we, misalign_err, wb_num, wb_data} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_out: got %h expected 0", {wb_valid, wb_we, misalign_err, wb_num, wb_data});
        end
        vectors++;
        if (wb_pc !== RST_PC) begin
            miscompares++;
            $display("FAIL reset_pc: got %h expected %h", wb_pc, RST_PC);
        end
        vectors++;
        if ({halted, retired_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: halted %b count %0d expected 0/0", halted, retired_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res[3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), res[i], 32'hDEAD_BEEF, 2'd0, 3'd0, 1'b1, 5'(8 + i), 1'b0);
            obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v || wb_we !== 1'b1 || wb_data !== res[i]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (retired_count !== 4'd3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d expected 3", retired_count);
        end
    endtask

    task automatic test_loads();
        logic [31:0] addr[4] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0000};
        logic [2:0]  lt[4]   = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] want[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500, addr[i], 32'h80FF_1234, 2'd1, lt[i], 1'b1, 5'd4, 1'b0);
            obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v || wb_data !== want[i]) begin
                miscompares++;
                $display("FAIL load[%0d]: got %h expected %h (data %h)", i, obs, exp_v, want[i]);
            end
        end
        for (int i = 0; i < 24; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'b0);
            obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL rand_load[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_misalign();
        logic [CNT_W-1:0] c0;
        do_reset();
        c0 = model_cnt;
        drive(1'b1, 32'h600, 32'h2000_0002, 32'h1111_2222, 2'd1, 3'd0, 1'b1, 5'd6, 1'b0);
        obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
        exp_v = exp_q.pop_front();
        vectors++;
        if (obs !== exp_v || misalign_err !== 1'b1 || wb_we !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_lw: got %h expected %h", obs, exp_v);
        end
        vectors++;
        if (retired_count !== c0 + 1'b1) begin
            miscompares++;
            $display("FAIL misalign_count: got %0d expected %0d", retired_count, c0 + 1'b1);
        end
        drive(1'b1, 32'h604, 32'h0000_0077, 32'h0, 2'd0, 3'd0, 1'b1, 5'd0, 1'b0);
        obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
        exp_v = exp_q.pop_front();
        vectors++;
        if (obs !== exp_v || misalign_err !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_reg: got %h expected %h", obs, exp_v);
        end
        drive(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'd2, 3'd0, 1'b1, 5'd31, 1'b0);
        obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
        exp_v = exp_q.pop_front();
        vectors++;
        if (obs !== exp_v || wb_data !== 32'h0 || wb_num !== 5'd31) begin
            miscompares++;
            $display("FAIL link_wrap: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_stall_flush();
        logic [39:0] held;
        do_reset();
        drive(1'b1, 32'h700, 32'h55, 32'h0, 2'd0, 3'd0, 1'b1, 5'd5, 1'b0);
        held = exp_q.pop_front();
        stall = 1'b1;
        in_valid = 1'b1; in_alu_result = 32'h99; in_wr_num = 5'd9; in_pc = 32'h704;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
            vectors++;
            if (obs !== held || retired_count !== model_cnt || wb_pc !== 32'h700) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h cnt %0d expected %h cnt %0d", i, obs, retired_count, held, model_cnt);
            end
        end
        drive(1'b1, 32'h708, 32'h2000_0001, 32'h0, 2'd1, 3'd3, 1'b1, 5'd3, 1'b0);
        exp_v = exp_q.pop_front();
        stall = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
        exp_v[37] = 1'b0;
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL stall_mis_clear: got %h expected %h", obs, exp_v);
        end
        stall = 1'b0;
        drive(1'b1, 32'h100, 32'h77, 32'h0, 2'd0, 3'd0, 1'b1, 5'd7, 1'b0);
        held = exp_q.pop_front();
        flush = 1'b1; stall = 1'b1;
        in_valid = 1'b1; in_alu_result = 32'hAA; in_wr_num = 5'd9; in_pc = 32'h104;
        @(posedge clk);
        #1;
        obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
        vectors++;
        if (obs !== {3'b000, held[36:0]} || wb_pc !== 32'h100 || retired_count !== model_cnt) begin
            miscompares++;
            $display("FAIL flush: got %h pc %h expected %h pc 100", obs, wb_pc, {3'b000, held[36:0]});
        end
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] c0;
        do_reset();
        drive(1'b1, 32'h200, 32'hAB, 32'h0, 2'd0, 3'd0, 1'b1, 5'd2, 1'b1);
        obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
        exp_v = exp_q.pop_front();
        vectors++;
        if (obs !== exp_v || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_write: got %h halted %b expected %h halted 1", obs, halted, exp_v);
        end
        c0 = retired_count;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h204 + 32'(i * 4), 32'h10 + 32'(i), 32'h0, 2'd0, 3'd0, 1'b1, 5'd12, 1'b0);
            obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v || wb_we !== 1'b0 || retired_count !== c0) begin
                miscompares++;
                $display("FAIL after_halt[%0d]: got %h cnt %0d expected %h cnt %0d", i, obs, retired_count, exp_v, c0);
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1; in_reg_we = 1'b1; in_wr_num = 5'd3;
        #1;
        vectors++;
        if ({halted, retired_count, wb_we, wb_valid} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: halted %b cnt %0d we %b valid %b expected all 0", halted, retired_count, wb_we, wb_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (wb_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold_we: got %b expected 0", wb_we);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_halted = 1'b0;
        model_cnt = '0;
        @(posedge clk);
        #1;
        vectors++;
        if (wb_we !== 1'b0 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_we: we %b valid %b expected 0 0", wb_we, wb_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h800 + 32'(i * 4), 32'(i), 32'h0, 2'd0, 3'd0, 1'b1, 5'd1, 1'b0);
            obs = {wb_valid, wb_we, misalign_err, wb_num, wb_data};
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sat_vec[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        vectors++;
        if (retired_count !== 4'hF || retired_count !== model_cnt) begin
            miscompares++;
            $display("FAIL saturate: got %0d expected 15", retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_misalign();
        test_stall_flush();
        test_halt();
        test_saturation();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter for the 5-stage MIPS pipeline.
- Captures MEM-stage results on posedge clk and formats load data (byte/halfword extract, sign/zero extend).
- Selects the writeback source and drives the register file write port (number, data, enable). The register file commits on the following negedge, so a write is visible to ID reads in the same cycle.
- Keeps a retired-instruction counter and a sticky halt flag.

Parameters:
- RESET_PC, 32'h0000_0000, value of wb_pc after reset.
- CNT_W, 32, width of retired_count.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold all stage registers this cycle.
- flush  input  1  load a bubble this cycle; overrides stall.
- in_valid  input  1  MEM stage holds a real instruction.
- in_pc  input  32  PC of the MEM-stage instruction.
- in_alu_result  input  32  ALU result; also the memory byte address for loads.
- in_mem_rdata  input  32  raw aligned word from data memory.
- in_wb_sel  input  2  writeback source: 0 ALU, 1 load, 2 link (in_pc+4), 3 ALU.
- in_load_type  input  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
- in_reg_we  input  1  instruction writes a GPR.
- in_wr_num  input  5  destination GPR.
- in_halt  input  1  instruction is syscall/halt.
- wb_num  output  5  register file write number.
- wb_data  output  32  register file write data.
- wb_we  output  1  register file write enable.
- wb_pc  output  32  PC of the instruction in WB, for debug.
- wb_valid  output  1  WB holds a real instruction.
- misalign_err  output  1  one-cycle pulse when a misaligned load is captured.
- halted  output  1  sticky; set when a valid halt retires.
- retired_count  output  CNT_W  count of valid instructions captured.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wb_num=0, wb_data=0, wb_we=0, wb_valid=0, misalign_err=0, halted=0, retired_count=0.
  - wb_pc=RESET_PC.
- Latency: one cycle. Inputs present before posedge N appear on the outputs after posedge N. Formatting is combinational ahead of the register, so outputs are glitch-free register outputs.
- Effective valid: ev = in_valid & ~halted.
- Load formatting, with off = in_alu_result[1:0] and little-endian order (off 0 selects bits 7:0):
  - LB/LBU take byte off, sign- or zero-extended to 32 bits.
  - LH/LHU take halfword in_alu_result[1] (0 selects bits 15:0), sign- or zero-extended.
  - LW passes the word through.
- Misalignment, checked only when ev & in_reg_we & in_wb_sel==1:
  - LH/LHU with off[0]=1, or LW with off!=0.
  - On capture: wb_we=0 and misalign_err=1 for that cycle only. The instruction still retires and is counted.
- wb_we = ev & in_reg_we & (in_wr_num!=0) & ~misaligned. Writes to $0 are always suppressed; wb_num and wb_data are still captured.
- Link data is in_pc+4; wrap-around is modulo 2^32.
- Cycle priority, evaluated per posedge:
  1. flush: load a bubble (wb_valid=0, wb_we=0, misalign_err=0). wb_num, wb_data and wb_pc hold. No count.
  2. stall: all registers hold, except misalign_err, which clears to 0.
  3. Otherwise capture. If ev: retired_count+1, saturating at all-ones. If ev & in_halt: halted=1.
- After halted=1, every capture is a bubble (wb_we=0, wb_valid=0, no count) until reset.
- The halt instruction's own write, if any, still occurs.
- Reset asserted mid-operation clears everything immediately. No write pulse may appear during or after reset until the first real capture.

Test Plan:
- Back-to-back ALU ops (in_wb_sel=0, wr_num 8, 9, 10; results 0x11, 0x22, 0x33): wb_we=1 on three consecutive cycles with matching num/data; retired_count=3.
- LB at addr 0x...03, rdata 0x80FF_1234: wb_data=0xFFFF_FF80. LBU at the same address gives 0x0000_0080. LH at addr ...2 gives 0xFFFF_80FF. LHU at addr ...0 gives 0x0000_1234.
- LW at addr 0x...02: wb_we=0, misalign_err high exactly one cycle, count increments. Write to $0 with in_reg_we=1: wb_we=0, wb_valid=1.
- JAL link at in_pc=0xFFFF_FFFC, wr_num=31: wb_data=0x0000_0000. stall held 3 cycles leaves outputs and count unchanged. flush together with stall gives wb_valid=0 and wb_we=0.
- Valid halt captured: halted=1 next cycle. Following valid ALU ops produce no writes and no count change. rst_n pulse low mid-stream clears halted and count asynchronously.
- Preload retired_count near saturation via 2^CNT_W-1 captures (CNT_W=4 build): count stays at 15.
